// File: rtl/button_classifier.sv
// Push-button front end: synchronises and debounces a raw, bouncy button pin,
// then classifies each debounced press as short or long. Each press produces
// exactly one single-cycle event on buttonState (1 = short, 2 = long).
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | button released, waiting for a debounced press
// PRESSED   | press in progress, hold_cnt measuring the hold time
// LONG_WAIT | long event already emitted, waiting silently for release
module button_classifier #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  output logic [1:0] buttonState,
  output logic       btn_level
);

  // A debounce window of one cycle would give a zero-width counter.
  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = $clog2(LONG_CYCLES);

  localparam logic [DEB_W-1:0]  DEB_LAST     = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX     = '1;
  localparam logic              RAW_RELEASED = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;

  localparam logic [1:0] EV_IDLE  = 2'd0;
  localparam logic [1:0] EV_SHORT = 2'd1;
  localparam logic [1:0] EV_LONG  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PRESSED   = 2'd1,
    S_LONG_WAIT = 2'd2
  } state_t;

  logic              raw_meta;
  logic              raw_sync;
  logic              sync;
  logic [DEB_W-1:0]  deb_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  state_t            state;

  // Two-flop synchroniser. The flops hold the pin in its raw polarity so they
  // can reset to the released pin level; the polarity inversion is a pure
  // wire on the output, so timing is identical to synchronising the
  // normalised signal.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      raw_meta <= RAW_RELEASED;
      raw_sync <= RAW_RELEASED;
    end else begin
      raw_meta <= btn_raw;
      raw_sync <= raw_meta;
    end
  end

  assign sync = BTN_ACTIVE_LOW ? ~raw_sync : raw_sync;

  // Debouncer: accept a new level only after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement; any agreeing cycle restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_cnt   <= '0;
      btn_level <= 1'b0;
    end else if (sync != btn_level) begin
      if (deb_cnt == DEB_LAST) begin
        btn_level <= sync;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  // Press classifier with registered single-cycle event output. Release is
  // tested before the long threshold so a release on the threshold cycle
  // still counts as short.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      hold_cnt    <= '0;
      buttonState <= EV_IDLE;
    end else begin
      buttonState <= EV_IDLE;
      case (state)
        S_IDLE: begin
          if (btn_level) begin
            state    <= S_PRESSED;
            hold_cnt <= '0;
          end
        end
        S_PRESSED: begin
          if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
          if (!btn_level) begin
            buttonState <= EV_SHORT;
            state       <= S_IDLE;
          end else if (hold_cnt == HOLD_LAST) begin
            buttonState <= EV_LONG;
            state       <= S_LONG_WAIT;
          end
        end
        S_LONG_WAIT: begin
          if (!btn_level) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
